// File: rtl/adc_sample_sequencer.sv
// Scans enabled AMUX channels with per-channel settle, runs the ADC start/done handshake and queues {channel,sample} words.
// All outputs registered; a push into a full FIFO with no same-cycle pop is dropped and flagged as overflow.
module adc_sample_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int NUM_CH        = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONV_TIMEOUT  = 255,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   trig_word,
  input  logic [NUM_CH-1:0]       chan_mask,
  input  logic                    clr_flags,
  output logic [CH_W-1:0]         amux_sel,
  output logic                    adc_start,
  input  logic                    adc_done,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   status
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W = $clog2(CONV_TIMEOUT + 1);
  localparam int ENT_W = 4 + SAMPLE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONVERT, S_STORE} state_t;

  state_t                  state_q, state_d;
  logic                    trig_q;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [SET_W-1:0]        set_cnt_q, set_cnt_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    start_q, start_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ENT_W-1:0]        mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_word;
  logic                    rd_valid_q;
  logic                    ovf_q, tmo_q, done_q, err_q;
  logic                    ovf_d, tmo_d, done_d, err_d;
  logic [DATA_WIDTH-1:0]   status_q, status_d;

  logic                    trig_rise, advance;
  logic                    err_set, tmo_set, done_set, ovf_set;
  logic                    pop, push, push_req, full;
  logic [CH_W-1:0]         start_ch, wrap_ch, next_ch;
  logic                    has_next;
  logic [ENT_W-1:0]        rd_ent;
  logic                    unused_trig;

  assign unused_trig = ^trig_word[DATA_WIDTH-1:2];
  assign trig_rise   = trig_word[0] & ~trig_q;

  // Descending scan leaves the lowest qualifying index in each result.
  always_comb begin
    start_ch = '0;
    wrap_ch  = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chan_mask[i]) start_ch = CH_W'(i);
      if (mask_q[i])    wrap_ch  = CH_W'(i);
      if (mask_q[i] && (CH_W'(i) > ch_q)) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    set_cnt_d = set_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    sample_d  = sample_q;
    start_d   = 1'b0;
    err_set   = 1'b0;
    tmo_set   = 1'b0;
    done_set  = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          mask_d = chan_mask;
          if (chan_mask == '0) begin
            err_set = 1'b1;
          end else begin
            ch_d      = start_ch;
            set_cnt_d = '0;
            state_d   = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d   = S_CONVERT;
          start_d   = 1'b1;
          tmo_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      S_CONVERT: begin
        // A done coinciding with the start pulse (count 0) is not accepted.
        if ((tmo_cnt_q != '0) && adc_done) begin
          sample_d = adc_data;
          state_d  = S_STORE;
        end else if (tmo_cnt_q == TMO_W'(CONV_TIMEOUT)) begin
          tmo_set = 1'b1;
          advance = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_STORE: advance = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      set_cnt_d = '0;
      if (has_next) begin
        ch_d    = next_ch;
        state_d = S_SETTLE;
      end else if (trig_word[1] && trig_word[0]) begin
        ch_d    = wrap_ch;
        state_d = S_SETTLE;
      end else begin
        state_d  = S_IDLE;
        done_set = 1'b1;
      end
    end
  end

  always_comb begin
    full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    pop      = rd_en && (cnt_q != '0);
    push_req = (state_q == S_STORE);
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    rd_ent                         = mem[rd_ptr_q];
    rd_word                        = '0;
    rd_word[SAMPLE_WIDTH-1:0]      = rd_ent[SAMPLE_WIDTH-1:0];
    rd_word[19:16]                 = rd_ent[ENT_W-1:SAMPLE_WIDTH];

    // Set events take priority over a same-cycle clear.
    ovf_d  = ovf_set  | (ovf_q  & ~clr_flags);
    tmo_d  = tmo_set  | (tmo_q  & ~clr_flags);
    done_d = done_set | (done_q & ~clr_flags);
    err_d  = err_set  | (err_q  & ~clr_flags);

    status_d        = '0;
    status_d[0]     = (state_d != S_IDLE);
    status_d[1]     = (cnt_d == '0);
    status_d[2]     = (cnt_d == CNT_W'(FIFO_DEPTH));
    status_d[3]     = ovf_d;
    status_d[4]     = tmo_d;
    status_d[5]     = done_d;
    status_d[6]     = err_d;
    status_d[11:8]  = 4'(ch_d);
    status_d[19:16] = (CNT_W > 4 && cnt_d > CNT_W'(15)) ? 4'hF : 4'(cnt_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      trig_q     <= 1'b0;
      mask_q     <= '0;
      ch_q       <= '0;
      set_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      sample_q   <= '0;
      start_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      status_q   <= DATA_WIDTH'(2);
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_word[0];
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      set_cnt_q  <= set_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      sample_q   <= sample_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= pop;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      status_q   <= status_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        rd_data_q <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {4'(ch_q), sample_q};
  end

  assign amux_sel  = ch_q;
  assign adc_start = start_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign status    = status_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: scan table plus hand-built overflow, timeout and reset sequences.
module tb_adc_sample_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] trig_word;
  logic [3:0]  chan_mask;
  logic        clr_flags;
  logic [1:0]  amux_sel;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] status;

  int          n_cmp, n_bad, cyc;
  int          adc_mode, done_cnt;
  logic        done_was;
  logic [11:0] next_data;
  logic        data_inc;
  int          n_starts;
  int          start_cyc [16];
  logic [1:0]  start_ch  [16];
  logic [31:0] last_rd;
  logic [1:0]  prev_sel;
  logic        wrap_seen;
  int          tmo_at;

  typedef struct {
    logic [3:0]  mask;
    logic [11:0] data;
    int          n;
    logic [15:0] chs;
  } vec_t;
  vec_t vecs [5];

  adc_sample_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .trig_word (trig_word),
    .chan_mask (chan_mask),
    .clr_flags (clr_flags),
    .amux_sel  (amux_sel),
    .adc_start (adc_start),
    .adc_done  (adc_done),
    .adc_data  (adc_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .status    (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] ent(input logic [3:0] ch, input logic [11:0] d);
    return {12'h000, ch, 4'h0, d};
  endfunction

  // One clock; also acts as the ADC model (done pulse 3 cycles after start).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    done_was = adc_done;
    adc_done = 1'b0;
    if (adc_start) begin
      if (n_starts < 16) begin
        start_cyc[n_starts] = cyc;
        start_ch[n_starts]  = amux_sel;
      end
      n_starts++;
      if (adc_mode == 1) done_cnt = 3;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        adc_done = 1'b1;
        adc_data = next_data;
        if (data_inc) next_data = next_data + 12'd1;
      end
    end
  endtask

  task automatic pop_chk(input string name, input logic [31:0] want);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({name, "_vld"}, {31'd0, rd_valid}, 32'd1);
    chk(name, rd_data, want);
    last_rd = want;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; trig_word = '0; chan_mask = '0; clr_flags = 1'b0;
    adc_done = 1'b0; adc_data = '0; rd_en = 1'b0;
    adc_mode = 1; done_cnt = 0; done_was = 1'b0; next_data = '0; data_inc = 1'b0;
    n_starts = 0; last_rd = '0; prev_sel = '0; wrap_seen = 1'b0; tmo_at = -1;

    vecs[0] = '{4'b0101, 12'hA5A, 2, 16'h0020};
    vecs[1] = '{4'b0000, 12'h000, 0, 16'h0000};
    vecs[2] = '{4'b1111, 12'h123, 4, 16'h3210};
    vecs[3] = '{4'b1000, 12'hFFF, 1, 16'h0003};
    vecs[4] = '{4'b0110, 12'h5C7, 2, 16'h0021};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_status", status, 32'h0000_0002);
    chk("rst_amux", {30'd0, amux_sel}, 32'd0);
    chk("rst_start", {31'd0, adc_start}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);

    // Single-scan table: per mask, entries, channel order and flags.
    for (int v = 0; v < 5; v++) begin
      chan_mask = vecs[v].mask;
      next_data = vecs[v].data;
      adc_mode  = 1;
      n_starts  = 0;
      clear_flags();
      trig_word = 32'd1;
      repeat (60) tick();
      chk($sformatf("v%0d_busy", v), {31'd0, status[0]}, 32'd0);
      chk($sformatf("v%0d_count", v), {28'd0, status[19:16]}, vecs[v].n);
      chk($sformatf("v%0d_seq_done", v), {31'd0, status[5]}, (vecs[v].n != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_err_mask", v), {31'd0, status[6]}, (vecs[v].n == 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_starts", v), n_starts, vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < n_starts && k < 16; k++)
        chk($sformatf("v%0d_start_ch%0d", v, k), {30'd0, start_ch[k]}, {28'd0, vecs[v].chs[4*k +: 4]});
      if (v == 0 && n_starts >= 2)
        chk("v0_start_spacing", start_cyc[1] - start_cyc[0], 32'd9);
      trig_word = 32'd0;
      tick();
      for (int k = 0; k < vecs[v].n; k++)
        pop_chk($sformatf("v%0d_rd%0d", v, k), ent(vecs[v].chs[4*k +: 4], vecs[v].data));
      chk($sformatf("v%0d_empty", v), {31'd0, status[1]}, 32'd1);
    end

    // err_mask clear, and set winning over a same-cycle clear.
    chan_mask = 4'b0000;
    trig_word = 32'd0; tick();
    trig_word = 32'd1; tick();
    chk("err_set", {31'd0, status[6]}, 32'd1);
    chk("err_busy", {31'd0, status[0]}, 32'd0);
    clear_flags();
    chk("err_clr", {31'd0, status[6]}, 32'd0);
    trig_word = 32'd0; tick();
    trig_word = 32'd1; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("err_set_wins", {31'd0, status[6]}, 32'd1);
    clear_flags();
    trig_word = 32'd0; tick();

    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("empty_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("empty_rd_hold", rd_data, last_rd);

    // Continuous scan, no reads: fill then overflow on the 9th sample.
    chan_mask = 4'b1111; next_data = 12'h3C3; n_starts = 0; wrap_seen = 1'b0;
    trig_word = 32'd3;
    prev_sel = amux_sel;
    for (int i = 0; i < 300 && !status[3]; i++) begin
      tick();
      if (status[0] && prev_sel == 2'd3 && amux_sel == 2'd0) wrap_seen = 1'b1;
      prev_sel = amux_sel;
    end
    chk("cont_overflow", {31'd0, status[3]}, 32'd1);
    chk("cont_count", {28'd0, status[19:16]}, 32'd8);
    chk("cont_full", {31'd0, status[2]}, 32'd1);
    chk("cont_wrap", {31'd0, wrap_seen}, 32'd1);
    chk("cont_starts", n_starts, 32'd9);
    trig_word = 32'd0;
    for (int i = 0; i < 100 && status[0]; i++) tick();
    chk("cont_idle", {31'd0, status[0]}, 32'd0);
    chk("cont_seq_done", {31'd0, status[5]}, 32'd1);
    for (int k = 0; k < 8; k++)
      pop_chk($sformatf("cont_rd%0d", k), ent(4'(k % 4), 12'h3C3));
    chk("cont_empty", {31'd0, status[1]}, 32'd1);

    // Full FIFO: pop in the same cycle as a STORE push.
    clear_flags();
    chan_mask = 4'b0001; next_data = 12'h100; data_inc = 1'b1;
    trig_word = 32'd3;
    for (int i = 0; i < 200 && status[19:16] != 4'd8; i++) tick();
    chk("ff_fill", {28'd0, status[19:16]}, 32'd8);
    for (int i = 0; i < 40 && !done_was; i++) tick();
    chk("ff_store_seen", {31'd0, done_was}, 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("ff_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("ff_rd_oldest", rd_data, ent(4'd0, 12'h100));
    chk("ff_count", {28'd0, status[19:16]}, 32'd8);
    chk("ff_full", {31'd0, status[2]}, 32'd1);
    chk("ff_no_ovf", {31'd0, status[3]}, 32'd0);
    trig_word = 32'd0;
    for (int k = 0; k < 8; k++)
      pop_chk($sformatf("ff_rd%0d", k + 1), ent(4'd0, 12'h101 + 12'(k)));
    for (int i = 0; i < 50 && status[0]; i++) tick();
    data_inc = 1'b0;
    chk("ff_idle_no_ovf", {31'd0, status[3]}, 32'd0);
    chk("ff_last_count", {28'd0, status[19:16]}, 32'd1);
    pop_chk("ff_rd9", ent(4'd0, 12'h109));

    // Silent ADC: each channel times out, nothing is queued.
    clear_flags();
    adc_mode = 0; chan_mask = 4'b0011; n_starts = 0; tmo_at = -1;
    trig_word = 32'd1;
    tick();
    for (int i = 0; i < 1200 && status[0]; i++) begin
      tick();
      if (tmo_at < 0 && status[4]) tmo_at = cyc;
    end
    chk("tmo_idle", {31'd0, status[0]}, 32'd0);
    chk("tmo_flag", {31'd0, status[4]}, 32'd1);
    chk("tmo_empty", {31'd0, status[1]}, 32'd1);
    chk("tmo_seq_done", {31'd0, status[5]}, 32'd1);
    chk("tmo_starts", n_starts, 32'd2);
    chk_rng("tmo_delay", tmo_at - start_cyc[0], 255, 257);
    chk_rng("tmo_ch_spacing", start_cyc[1] - start_cyc[0], 259, 262);
    trig_word = 32'd0; tick();

    // Reset during CONVERT, then a late done.
    clear_flags();
    chan_mask = 4'b0001; n_starts = 0;
    trig_word = 32'd1;
    for (int i = 0; i < 20 && n_starts == 0; i++) tick();
    tick(); tick();
    chk("rst_conv_busy", {31'd0, status[0]}, 32'd1);
    reset = 1'b1; trig_word = 32'd0;
    tick();
    reset = 1'b0;
    chk("rst_conv_status", status, 32'h0000_0002);
    chk("rst_conv_rd_data", rd_data, 32'd0);
    adc_done = 1'b1; adc_data = 12'hBAD;
    tick();
    repeat (3) tick();
    chk("late_done_status", status, 32'h0000_0002);
    chk("late_done_amux", {30'd0, amux_sel}, 32'd0);
    chk("late_done_start", {31'd0, adc_start}, 32'd0);
    chk("late_done_rd_valid", {31'd0, rd_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
